// File: rtl/ternary_word_decoder_if.sv
// Handshake bundle for the ternary word decoder: an input word stream
// and a binary result stream, each with valid/ready flow control.
interface ternary_word_decoder_if #(
    parameter int TRITS = 9,
    parameter int BIN_W = 16
) ();
    logic               in_valid;
    logic               in_ready;
    logic [2*TRITS-1:0] in_trits;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   out_data;
    logic               out_err;

    // Upstream/downstream environment side
    modport master (
        output in_valid,
        input  in_ready,
        output in_trits,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_err
    );

    // Decoder side
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_trits,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_err
    );
endinterface

// File: rtl/ternary_word_decoder.sv
// Balanced-ternary to two's-complement converter. A captured word is
// folded MSB first with Horner's rule (acc = 3*acc + trit), one trit per
// cycle, then held in DONE until the downstream handshake completes.
module ternary_word_decoder #(
    parameter int TRITS = 9,
    parameter int BIN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ternary_word_decoder_if.slave bus
);
    localparam int WORD_W = 2 * TRITS;
    localparam int IDX_W  = (TRITS > 1) ? $clog2(TRITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [WORD_W-1:0]         word;
    logic signed [BIN_W-1:0]   acc;
    logic                      err;
    logic [IDX_W-1:0]          idx;
    logic                      in_ready_r;
    logic                      out_valid_r;
    logic [1:0]                cur_trit;

    // Map a trit code to its signed value; the invalid code contributes 0.
    function automatic logic signed [BIN_W-1:0] trit_value(input logic [1:0] code);
        logic signed [BIN_W-1:0] v;
        case (code)
            2'b01:   v = {{(BIN_W-1){1'b0}}, 1'b1};
            2'b10:   v = '1;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Times-three with natural wrap-around modulo 2^BIN_W.
    function automatic logic signed [BIN_W-1:0] times_three(input logic signed [BIN_W-1:0] a);
        return (a <<< 1) + a;
    endfunction

    // The captured word is shifted left each step so the trit being
    // processed always sits in the top two bits.
    assign cur_trit = word[WORD_W-1 -: 2];

    // Control FSM plus datapath registers; reset overrides every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word        <= '0;
            acc         <= '0;
            err         <= 1'b0;
            idx         <= IDX_W'(TRITS - 1);
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word       <= bus.in_trits;
                        acc        <= '0;
                        err        <= 1'b0;
                        idx        <= IDX_W'(TRITS - 1);
                        in_ready_r <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    acc  <= times_three(acc) + trit_value(cur_trit);
                    err  <= err | (cur_trit == 2'b11);
                    word <= word << 2;
                    if (idx == '0) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = acc;
    assign bus.out_err   = err;
endmodule

// File: tb/tb_ternary_word_decoder.sv
// Self-checking bench for ternary_word_decoder (TRITS=9, BIN_W=16).
// Reference values come from a positional sum of trit*3^i.
module tb_ternary_word_decoder;
    localparam int TR = 9;
    localparam int BW = 16;
    localparam int WW = 2 * TR;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ternary_word_decoder_if #(.TRITS(TR), .BIN_W(BW)) bus ();

    ternary_word_decoder #(.TRITS(TR), .BIN_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Positional reference: value = sum(trit_i * 3^i), truncated to BW bits.
    function automatic void ref_decode(input logic [WW-1:0] w,
                                       output logic [BW-1:0] v, output logic e);
        int s;
        int p;
        logic [1:0] c;
        s = 0;
        p = 1;
        e = 1'b0;
        for (int i = 0; i < TR; i++) begin
            c = w[2*i +: 2];
            if (c == 2'b01) s = s + p;
            else if (c == 2'b10) s = s - p;
            else if (c == 2'b11) e = 1'b1;
            p = p * 3;
        end
        v = s[BW-1:0];
    endfunction

    function automatic logic [WW-1:0] rand_word(input int err_pct);
        logic [WW-1:0] w;
        int r;
        w = '0;
        for (int i = 0; i < TR; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < err_pct) w[2*i +: 2] = 2'b11;
            else begin
                r = int'($urandom_range(0, 2));
                w[2*i +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
            end
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word until accepted; garbage replaces it afterwards.
    task automatic send_word(input logic [WW-1:0] w, output bit ok);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            step();
            n++;
        end
        ok = bus.in_ready;
        bus.in_valid = 1'b1;
        bus.in_trits = w;
        step();
        bus.in_valid = 1'b0;
        bus.in_trits = WW'($urandom);
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        ok = bus.out_valid;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic decode_word(input logic [WW-1:0] w, output logic [BW-1:0] d,
                               output logic e, output int lat, output bit ok);
        bit ok1;
        bit ok2;
        send_word(w, ok1);
        wait_valid(lat, ok2);
        ok = ok1 && ok2;
        d = bus.out_data;
        e = bus.out_err;
        handshake();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_trits = '0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
        checks++;
        if (bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b want=0", bus.out_err); end
    endtask

    task automatic test_directed();
        logic [WW-1:0] words [4];
        logic [BW-1:0] exp_d [4];
        logic          exp_e [4];
        logic [BW-1:0] d;
        logic          e;
        int            lat;
        bit            ok;
        words[0] = 18'h15555; exp_d[0] = 16'h2671; exp_e[0] = 1'b0;
        words[1] = 18'h2AAAA; exp_d[1] = 16'hD98F; exp_e[1] = 1'b0;
        words[2] = 18'h00012; exp_d[2] = 16'd8;    exp_e[2] = 1'b0;
        words[3] = 18'h00300; exp_d[3] = 16'd0;    exp_e[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            decode_word(words[k], d, e, lat, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL directed_timeout word=%0d", k); end
            checks++;
            if (d !== exp_d[k]) begin failures++; $display("FAIL directed_data word=%0d got=%h want=%h", k, d, exp_d[k]); end
            checks++;
            if (e !== exp_e[k]) begin failures++; $display("FAIL directed_err word=%0d got=%b want=%b", k, e, exp_e[k]); end
            checks++;
            if (lat != TR) begin failures++; $display("FAIL directed_latency word=%0d got=%0d want=%0d", k, lat, TR); end
        end
    endtask

    task automatic test_random();
        logic [WW-1:0] w;
        logic [BW-1:0] d;
        logic [BW-1:0] exp_d;
        logic          e;
        logic          exp_e;
        int            lat;
        bit            ok;
        for (int k = 0; k < 30; k++) begin
            w = rand_word(8);
            ref_decode(w, exp_d, exp_e);
            decode_word(w, d, e, lat, ok);
            checks++;
            if (!ok || d !== exp_d || e !== exp_e)
            begin
                failures++;
                $display("FAIL random word=%h ok=%0b got=%h/%b want=%h/%b", w, ok, d, e, exp_d, exp_e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] w;
        logic [BW-1:0] exp_d;
        logic          exp_e;
        int            lat;
        bit            ok;
        w = rand_word(0);
        if (w == '0) w = 18'h00001;
        ref_decode(w, exp_d, exp_e);
        send_word(w, ok);
        wait_valid(lat, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_timeout lat=%0d", lat); end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_trits = rand_word(0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.in_ready !== 1'b0)
            begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b data=%h ready=%b want 1/%h/0",
                         c, bus.out_valid, bus.out_data, bus.in_ready, exp_d);
            end
            step();
        end
        bus.in_valid = 1'b0;
        handshake();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
        begin
            failures++;
            $display("FAIL bp_release ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.out_data !== exp_d) begin failures++; $display("FAIL bp_no_capture got=%h want=%h", bus.out_data, exp_d); end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w;
        logic [BW-1:0] d;
        logic [BW-1:0] exp_d;
        logic          e;
        logic          exp_e;
        int            lat;
        bit            ok;
        send_word(18'h15555, ok);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0)
        begin
            failures++;
            $display("FAIL rst_conv valid=%b ready=%b data=%h want 0/1/0000", bus.out_valid, bus.in_ready, bus.out_data);
        end
        w = rand_word(10);
        ref_decode(w, exp_d, exp_e);
        decode_word(w, d, e, lat, ok);
        checks++;
        if (!ok || d !== exp_d || e !== exp_e || lat != TR)
        begin
            failures++;
            $display("FAIL rst_after_word got=%h/%b lat=%0d want=%h/%b lat=%0d", d, e, lat, exp_d, exp_e, TR);
        end
        // Reset coinciding with the output handshake in DONE
        send_word(18'h15555, ok);
        wait_valid(lat, ok);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (!ok || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0 || bus.out_err !== 1'b0)
        begin
            failures++;
            $display("FAIL rst_done ok=%0b valid=%b ready=%b data=%h err=%b want 0/1/0000/0",
                     ok, bus.out_valid, bus.in_ready, bus.out_data, bus.out_err);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 5;
        logic [WW-1:0] words [N];
        logic [BW-1:0] exp_d;
        logic          exp_e;
        int            k;
        int            dn;
        int            cyc;
        int            last;
        for (int i = 0; i < N; i++) words[i] = rand_word(10);
        k = 0;
        dn = 0;
        last = -1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (cyc = 0; cyc < 200 && dn < N; cyc++) begin
            if (bus.out_valid) begin
                ref_decode(words[dn], exp_d, exp_e);
                checks++;
                if (bus.out_data !== exp_d || bus.out_err !== exp_e)
                begin
                    failures++;
                    $display("FAIL b2b_data word=%0d got=%h/%b want=%h/%b", dn, bus.out_data, bus.out_err, exp_d, exp_e);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 11) begin failures++; $display("FAIL b2b_period word=%0d got=%0d want=11", dn, cyc - last); end
                end
                last = cyc;
                dn++;
            end
            if (bus.in_ready) begin
                if (k < N) begin
                    bus.in_trits = words[k];
                    k++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end else begin
                bus.in_trits = WW'($urandom);
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (dn != N) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", dn, N); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
